// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA plot writer: framebuffer geometry,
// writer state encoding and the linear address helper.
package vga_pkg;

    localparam int unsigned FB_ADDR_W  = 15;
    localparam int unsigned COLOR_W    = 15;
    localparam int unsigned X_W        = 8;
    localparam int unsigned Y_W        = 7;
    localparam int unsigned WIDTH_DEF  = 160;
    localparam int unsigned HEIGHT_DEF = 120;

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StClear
    } state_e;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [COLOR_W-1:0]   color;
    } plot_entry_t;

    // y*160 + x as y*128 + y*32 + x; fits in 15 bits for in-range coordinates.
    function automatic logic [FB_ADDR_W-1:0] fb_addr_calc(input logic [X_W-1:0] x,
                                                          input logic [Y_W-1:0] y);
        logic [FB_ADDR_W-1:0] w_y;
        w_y = FB_ADDR_W'(y);
        return (w_y << 7) + (w_y << 5) + FB_ADDR_W'(x);
    endfunction

endpackage

// File: rtl/plot_fifo.sv
// Synchronous FIFO with registered storage; head word is visible on rdata while
// not empty. Pushes when full and pops when empty are ignored.
module plot_fifo #(
    parameter int unsigned WIDTH = 30,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign rdata  = r_mem[r_rd_ptr];
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers wrap naturally since DEPTH is a power of two.
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= wdata;
    end

endmodule

// File: rtl/vga_plot_writer.sv
// Turns the flow core's plot stream into framebuffer writes through a small
// queue, and runs a full-screen clear sweep on each rising edge of clear.
module vga_plot_writer
    import vga_pkg::*;
#(
    parameter int unsigned         FIFO_DEPTH  = 8,
    parameter int unsigned         WIDTH       = WIDTH_DEF,
    parameter int unsigned         HEIGHT      = HEIGHT_DEF,
    parameter logic [COLOR_W-1:0]  CLEAR_COLOR = 15'h0000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   plot,
    input  logic [X_W-1:0]         x,
    input  logic [Y_W-1:0]         y,
    input  logic [COLOR_W-1:0]     color,
    input  logic                   clear,
    output logic                   fb_we,
    output logic [FB_ADDR_W-1:0]   fb_addr,
    output logic [COLOR_W-1:0]     fb_data,
    input  logic                   fb_ready,
    output logic                   busy,
    output logic                   overflow,
    output logic                   dropped,
    output logic [3:0]             fifo_count
);

    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned ENTRY_W   = $bits(plot_entry_t);
    localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(WIDTH * HEIGHT - 1);

    state_e               r_state, w_state_d;
    logic                 r_we, w_we_d;
    logic [FB_ADDR_W-1:0] r_addr, w_addr_d;
    logic [COLOR_W-1:0]   r_data, w_data_d;
    logic                 r_clear_q;
    logic                 r_clr_pend, w_clr_pend_d;
    logic                 r_overflow;
    logic                 r_dropped;

    logic                 w_in_range;
    logic                 w_push_req;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [CNT_W-1:0]     w_count;
    plot_entry_t          w_wentry;
    plot_entry_t          w_head;
    logic                 w_clear_rise;
    logic                 w_clear_req;
    logic                 w_out_free;

    assign w_in_range   = (32'(x) < WIDTH) && (32'(y) < HEIGHT);
    assign w_push_req   = plot & w_in_range;
    assign w_wentry     = '{addr: fb_addr_calc(x, y), color: color};
    assign w_clear_rise = clear & ~r_clear_q;
    assign w_clear_req  = r_clr_pend | w_clear_rise;
    assign w_out_free   = ~r_we | fb_ready;

    plot_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_push_req),
        .wdata (w_wentry),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_comb begin
        w_state_d    = r_state;
        w_we_d       = r_we;
        w_addr_d     = r_addr;
        w_data_d     = r_data;
        w_pop        = 1'b0;
        w_clr_pend_d = w_clear_req;
        unique case (r_state)
            StIdle: begin
                if (w_clear_req) begin
                    w_state_d    = StClear;
                    w_we_d       = 1'b1;
                    w_addr_d     = '0;
                    w_data_d     = CLEAR_COLOR;
                    w_clr_pend_d = 1'b0;
                end else if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_state_d = StDrain;
                    w_we_d    = 1'b1;
                    w_addr_d  = w_head.addr;
                    w_data_d  = w_head.color;
                end
            end
            StDrain: begin
                // A clear waits for the in-flight write so the handshake stays stable.
                if (w_out_free) begin
                    if (w_clear_req) begin
                        w_state_d    = StClear;
                        w_we_d       = 1'b1;
                        w_addr_d     = '0;
                        w_data_d     = CLEAR_COLOR;
                        w_clr_pend_d = 1'b0;
                    end else if (!w_empty) begin
                        w_pop    = 1'b1;
                        w_we_d   = 1'b1;
                        w_addr_d = w_head.addr;
                        w_data_d = w_head.color;
                    end else begin
                        w_state_d = StIdle;
                        w_we_d    = 1'b0;
                    end
                end
            end
            StClear: begin
                if (fb_ready) begin
                    if (w_clear_req) begin
                        w_addr_d     = '0;
                        w_clr_pend_d = 1'b0;
                    end else if (r_addr == LAST_ADDR) begin
                        if (!w_empty) begin
                            w_pop     = 1'b1;
                            w_state_d = StDrain;
                            w_addr_d  = w_head.addr;
                            w_data_d  = w_head.color;
                        end else begin
                            w_state_d = StIdle;
                            w_we_d    = 1'b0;
                        end
                    end else begin
                        w_addr_d = r_addr + FB_ADDR_W'(1);
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
                w_we_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= StIdle;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_clear_q  <= 1'b0;
            r_clr_pend <= 1'b0;
            r_overflow <= 1'b0;
            r_dropped  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_we       <= w_we_d;
            r_addr     <= w_addr_d;
            r_data     <= w_data_d;
            r_clear_q  <= clear;
            r_clr_pend <= w_clr_pend_d;
            // Full is judged before any same-cycle pop, so the plot is lost.
            if (w_push_req && w_full) r_overflow <= 1'b1;
            if (plot && !w_in_range)  r_dropped  <= 1'b1;
        end
    end

    assign fb_we      = r_we;
    assign fb_addr    = r_addr;
    assign fb_data    = r_data;
    assign busy       = ~w_empty | r_we | (r_state == StClear);
    assign overflow   = r_overflow;
    assign dropped    = r_dropped;
    assign fifo_count = 4'(w_count);

endmodule
